// File: rtl/serial_byte_receiver.sv
// serial_byte_receiver: 8N1 UART receiver with 16x oversampling, 3-sample majority vote,
// false-start rejection, framing-error detection and idle / end-of-packet reporting.
//   i_clk           system clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_rx            asynchronous serial input, idles high
//   o_data_ready    one-cycle pulse, o_data holds a newly received byte
//   o_data          last good byte, held until the next good byte
//   o_frame_err     one-cycle pulse, stop bit sampled low
//   o_idle          line high for at least IDLE_BITS bit times
//   o_endofpacket   one-cycle pulse when o_idle rises after at least one byte
module serial_byte_receiver #(
    parameter int DIVISOR   = 27,
    parameter int IDLE_BITS = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic       o_data_ready,
    output logic [7:0] o_data,
    output logic       o_frame_err,
    output logic       o_idle,
    output logic       o_endofpacket
);
    localparam int DIV_W   = $clog2(DIVISOR);
    localparam int GAP_MAX = IDLE_BITS * 16;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_sync;
    logic [DIV_W-1:0]   r_div;
    logic [3:0]         r_ph;
    logic               r_s7;
    logic               r_s8;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit;
    logic               r_data_ready;
    logic [7:0]         r_data;
    logic               r_frame_err;
    logic [GAP_W-1:0]   r_gap;
    logic               r_idle_d;
    logic               r_got;

    logic               w_rxs;
    logic               w_start;
    logic               w_tick;
    logic [3:0]         w_ph_next;
    logic               w_at7;
    logic               w_at8;
    logic               w_at9;
    logic               w_wrap;
    logic               w_maj;
    logic               w_good_stop;
    logic               w_bad_stop;
    logic               w_idle;
    logic               w_eop;

    assign w_rxs       = r_sync[1];
    assign w_start     = (r_state == S_IDLE) && !w_rxs;
    assign w_tick      = (r_div == DIV_W'(DIVISOR - 1));
    // Sample points are named by the phase value the tick advances into, so the
    // decision lands 9 ticks after the start edge (centre of the bit).
    assign w_ph_next   = r_ph + 4'd1;
    assign w_at7       = w_tick && (w_ph_next == 4'd7);
    assign w_at8       = w_tick && (w_ph_next == 4'd8);
    assign w_at9       = w_tick && (w_ph_next == 4'd9);
    assign w_wrap      = w_tick && (r_ph == 4'd15);
    assign w_maj       = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);
    assign w_good_stop = (r_state == S_STOP) && w_at9 && w_maj;
    assign w_bad_stop  = (r_state == S_STOP) && w_at9 && !w_maj;
    assign w_idle      = (r_gap == GAP_W'(GAP_MAX));
    assign w_eop       = w_idle && !r_idle_d && r_got;

    assign o_data_ready  = r_data_ready;
    assign o_data        = r_data;
    assign o_frame_err   = r_frame_err;
    assign o_idle        = w_idle;
    assign o_endofpacket = w_eop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = w_rxs ? S_IDLE : S_START;
            S_START: w_state_next = (w_at9 && w_maj) ? S_IDLE : (w_wrap ? S_DATA : S_START);
            S_DATA:  w_state_next = (w_wrap && r_bit == 3'd7) ? S_STOP : S_DATA;
            S_STOP:  w_state_next = w_at9 ? (w_maj ? S_IDLE : S_BREAK) : S_STOP;
            // Hold here until the line recovers so a stuck-low line cannot re-trigger.
            S_BREAK: w_state_next = w_rxs ? S_IDLE : S_BREAK;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync       <= 2'b11;
            r_div        <= '0;
            r_ph         <= '0;
            r_s7         <= 1'b1;
            r_s8         <= 1'b1;
            r_shift      <= '0;
            r_bit        <= '0;
            r_data_ready <= 1'b0;
            r_data       <= '0;
            r_frame_err  <= 1'b0;
            r_gap        <= GAP_W'(GAP_MAX);
            r_idle_d     <= 1'b1;
            r_got        <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            // Start detect realigns the oversample grid to the falling edge.
            r_div  <= (w_start || w_tick) ? '0 : r_div + DIV_W'(1);
            r_ph   <= w_start ? '0 : (w_tick ? w_ph_next : r_ph);
            if (w_at7) r_s7 <= w_rxs;
            if (w_at8) r_s8 <= w_rxs;
            if (r_state == S_DATA && w_at9) r_shift <= {w_maj, r_shift[7:1]};
            if (r_state == S_START) r_bit <= '0;
            else if (r_state == S_DATA && w_wrap) r_bit <= r_bit + 3'd1;
            r_data_ready <= w_good_stop;
            r_frame_err  <= w_bad_stop;
            if (w_good_stop) r_data <= r_shift;
            r_gap <= w_start ? '0
                   : (r_state == S_IDLE && w_rxs && w_tick && !w_idle) ? r_gap + GAP_W'(1)
                   : r_gap;
            r_idle_d <= w_idle;
            r_got    <= w_eop ? 1'b0 : (r_data_ready ? 1'b1 : r_got);
        end
    end
endmodule

// File: tb/tb_serial_byte_receiver.sv
// tb_serial_byte_receiver: directed bench for serial_byte_receiver at DIVISOR=4 (64 clocks/bit).
module tb_serial_byte_receiver;
    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       data_ready;
    logic [7:0] data;
    logic       frame_err;
    logic       idle;
    logic       endofpacket;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int dr_cnt = 0;
    int fe_cnt = 0;
    int eop_cnt = 0;
    int both_cnt = 0;
    int idle_hi = 0;
    int t_dr = 0;
    int t_eop = 0;
    logic mon_en = 1'b0;
    logic [7:0] bytes [0:63];

    serial_byte_receiver #(.DIVISOR(4), .IDLE_BITS(16)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_rx(rx),
        .o_data_ready(data_ready),
        .o_data(data),
        .o_frame_err(frame_err),
        .o_idle(idle),
        .o_endofpacket(endofpacket)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (data_ready) begin
            bytes[dr_cnt % 64] = data;
            dr_cnt++;
            t_dr = cyc;
        end
        if (frame_err) fe_cnt++;
        if (endofpacket) begin
            eop_cnt++;
            t_eop = cyc;
        end
        if (data_ready && frame_err) both_cnt++;
        if (mon_en && idle) idle_hi++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    // Drives the first ncyc clocks of a frame {stop, b, start}, inverting rx during [gs, gs+gl).
    task automatic send_frame(input logic [7:0] b, input logic stop, input int gs, input int gl, input int ncyc);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            rx = f[i / 64] ^ ((i >= gs) && (i < gs + gl));
        end
    endtask

    task automatic wait_eop(input int base);
        for (int k = 0; k < 2000 && eop_cnt == base; k++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %b expected 0", data_ready); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (endofpacket !== 1'b0) begin errors++; $display("FAIL reset_eop: got %b expected 0", endofpacket); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single_byte;
        int d0, f0, e0;
        d0 = dr_cnt; f0 = fe_cnt; e0 = eop_cnt;
        send_frame(8'hA5, 1'b1, 0, 0, 640);
        wait_eop(e0);
        repeat (20) @(negedge clk);
        checks++; if (dr_cnt - d0 != 1) begin errors++; $display("FAIL single_dr_count: got %0d expected 1", dr_cnt - d0); end
        checks++; if (data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", data); end
        checks++; if (fe_cnt - f0 != 0) begin errors++; $display("FAIL single_frame_err: got %0d expected 0", fe_cnt - f0); end
        checks++; if (eop_cnt - e0 != 1) begin errors++; $display("FAIL single_eop_count: got %0d expected 1", eop_cnt - e0); end
        checks++; if (t_eop - t_dr != 1024) begin errors++; $display("FAIL single_eop_delay: got %0d expected 1024", t_eop - t_dr); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b expected 1", idle); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b [0:3];
        int d0, e0, h0;
        exp_b[0] = 8'hBC; exp_b[1] = 8'h82; exp_b[2] = 8'h32; exp_b[3] = 8'h00;
        d0 = dr_cnt; e0 = eop_cnt; h0 = idle_hi;
        fork
            for (int j = 0; j < 4; j++) send_frame(exp_b[j], 1'b1, 0, 0, 640);
            begin
                repeat (8) @(negedge clk);
                mon_en = 1'b1;
            end
        join
        mon_en = 1'b0;
        checks++; if (idle_hi - h0 != 0) begin errors++; $display("FAIL b2b_idle_low: idle high for %0d cycles, expected 0", idle_hi - h0); end
        checks++; if (dr_cnt - d0 != 4) begin errors++; $display("FAIL b2b_dr_count: got %0d expected 4", dr_cnt - d0); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (bytes[(d0 + j) % 64] !== exp_b[j]) begin
                errors++; $display("FAIL b2b_byte%0d: got %h expected %h", j, bytes[(d0 + j) % 64], exp_b[j]);
            end
        end
        wait_eop(e0);
        repeat (20) @(negedge clk);
        checks++; if (eop_cnt - e0 != 1) begin errors++; $display("FAIL b2b_eop_count: got %0d expected 1", eop_cnt - e0); end
    endtask

    task automatic test_false_start;
        int d0, f0, e0;
        d0 = dr_cnt; f0 = fe_cnt; e0 = eop_cnt;
        send_frame(8'h00, 1'b1, 0, 0, 20);
        @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (dr_cnt - d0 != 0) begin errors++; $display("FAIL false_start_dr: got %0d expected 0", dr_cnt - d0); end
        checks++; if (fe_cnt - f0 != 0) begin errors++; $display("FAIL false_start_fe: got %0d expected 0", fe_cnt - f0); end
        checks++; if (eop_cnt - e0 != 0) begin errors++; $display("FAIL false_start_eop: got %0d expected 0", eop_cnt - e0); end
        send_frame(8'h3C, 1'b1, 0, 0, 640);
        repeat (20) @(negedge clk);
        checks++; if (dr_cnt - d0 != 1) begin errors++; $display("FAIL false_start_next_count: got %0d expected 1", dr_cnt - d0); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL false_start_next_data: got %h expected 3c", data); end
    endtask

    task automatic test_frame_error;
        int d0, f0, e0;
        d0 = dr_cnt; f0 = fe_cnt;
        send_frame(8'h55, 1'b0, 0, 0, 640);
        repeat (200) @(negedge clk);
        rx = 1'b1;
        repeat (64) @(negedge clk);
        checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL frame_err_count: got %0d expected 1", fe_cnt - f0); end
        checks++; if (dr_cnt - d0 != 0) begin errors++; $display("FAIL frame_err_dr: got %0d expected 0", dr_cnt - d0); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL frame_err_data_held: got %h expected 3c", data); end
        e0 = eop_cnt;
        send_frame(8'h66, 1'b1, 0, 0, 640);
        repeat (20) @(negedge clk);
        checks++; if (data !== 8'h66) begin errors++; $display("FAIL frame_err_recover: got %h expected 66", data); end
        wait_eop(e0);
        checks++; if (eop_cnt - e0 != 1) begin errors++; $display("FAIL frame_err_eop: got %0d expected 1", eop_cnt - e0); end
    endtask

    task automatic test_majority;
        int d0, f0, e0;
        d0 = dr_cnt; f0 = fe_cnt; e0 = eop_cnt;
        // Glitch covers only the middle sample of data bit 2.
        send_frame(8'h0F, 1'b1, 223, 4, 640);
        repeat (20) @(negedge clk);
        checks++; if (data !== 8'h0F) begin errors++; $display("FAIL majority_data: got %h expected 0f", data); end
        checks++; if (dr_cnt - d0 != 1) begin errors++; $display("FAIL majority_dr: got %0d expected 1", dr_cnt - d0); end
        checks++; if (fe_cnt - f0 != 0) begin errors++; $display("FAIL majority_fe: got %0d expected 0", fe_cnt - f0); end
        wait_eop(e0);
    endtask

    task automatic test_reset_mid_frame;
        int d0, f0, e0;
        send_frame(8'hC3, 1'b1, 0, 0, 352);
        @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", data); end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL midrst_dr: got %b expected 0", data_ready); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_fe: got %b expected 0", frame_err); end
        checks++; if (endofpacket !== 1'b0) begin errors++; $display("FAIL midrst_eop: got %b expected 0", endofpacket); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL midrst_idle: got %b expected 1", idle); end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        d0 = dr_cnt; f0 = fe_cnt; e0 = eop_cnt;
        repeat (700) @(negedge clk);
        checks++; if (dr_cnt - d0 != 0) begin errors++; $display("FAIL midrst_no_dr: got %0d expected 0", dr_cnt - d0); end
        checks++; if (fe_cnt - f0 != 0) begin errors++; $display("FAIL midrst_no_fe: got %0d expected 0", fe_cnt - f0); end
        checks++; if (eop_cnt - e0 != 0) begin errors++; $display("FAIL midrst_no_eop: got %0d expected 0", eop_cnt - e0); end
        send_frame(8'h81, 1'b1, 0, 0, 640);
        repeat (20) @(negedge clk);
        checks++; if (data !== 8'h81) begin errors++; $display("FAIL midrst_next_data: got %h expected 81", data); end
    endtask

    initial begin
        rst_n = 1'b0;
        rx = 1'b1;
        test_reset;
        test_single_byte;
        test_back_to_back;
        test_false_start;
        test_frame_error;
        test_majority;
        test_reset_mid_frame;
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL pulse_exclusive: dr and fe together %0d times, expected 0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
